mem_arbiter: RTL and testbench

Two-client arbiter that shares the single main-memory port (req/we/addr/wdata, ready/done/rdata handshake) between the data-cache controller (client 0) and a second master (client 1, e.g. instruction cache or DMA). It sits directly in front of main memory. It serialises transactions with round-robin fairness. A lock lets one client hold the port across a multi-word block refill. A watchdog releases the port if memory never answers.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_pick2.sv | 21 ++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   // Watchdog counter width; bounds the usable TIMEOUT to 1..255.
   localparam int unsigned WDOG_W = 8;

   // Client indices as carried on the owner / winner signals.
   localparam logic C0 = 1'b0;
   localparam logic C1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the client that was not last.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner
);

   // Winner select; with no request the previous owner is kept (result unused then).
   always_comb begin
      winner = last;
      case (req)
         2'b01:   winner = C0;
         2'b10:   winner = C1;
         2'b11:   winner = ~last;
         default: winner = last;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between two clients with round-robin, lock and watchdog abort.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              c0_req,
   input  logic              c0_we,
   input  logic              c0_lock,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_wdata,
   input  logic              c1_req,
   input  logic              c1_we,
   input  logic              c1_lock,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_wdata,
   output logic              c0_gnt,
   output logic              c0_done,
   output logic [DATA_W-1:0] c0_rdata,
   output logic              c1_gnt,
   output logic              c1_done,
   output logic [DATA_W-1:0] c1_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner,
   output logic              busy,
   output logic              timeout_err
);

   state_t            state;
   state_t            state_d;
   logic [WDOG_W-1:0] wdog;
   logic              pick_c;
   logic              grant_c;
   logic              grant_sel_c;
   logic              accept_c;
   logic              finish_c;
   logic              abort_c;
   logic              own_req_c;
   logic              own_lock_c;

   assign own_req_c  = (owner == C1) ? c1_req  : c0_req;
   assign own_lock_c = (owner == C1) ? c1_lock : c0_lock;

   rr_pick2 u_pick (
      .req    ({c1_req, c0_req}),
      .last   (owner),
      .winner (pick_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   // Next state and single-cycle control strobes.
   always_comb begin
      state_d     = state;
      grant_c     = 1'b0;
      grant_sel_c = owner;
      accept_c    = 1'b0;
      finish_c    = 1'b0;
      abort_c     = 1'b0;
      case (state)
         S_IDLE: begin
            if ((c0_req || c1_req) && mem_ready) begin
               grant_c     = 1'b1;
               grant_sel_c = pick_c;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (mem_ready) begin
               accept_c = 1'b1;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            // A completion in the final watchdog cycle still counts as a normal finish.
            if (mem_done) begin
               finish_c = 1'b1;
               state_d  = own_lock_c ? S_HOLD : S_IDLE;
            end else if (wdog == WDOG_W'(TIMEOUT)) begin
               abort_c = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_HOLD: begin
            if (own_req_c && mem_ready) begin
               grant_c = 1'b1;
               state_d = S_ISSUE;
            end else if (!own_lock_c && !own_req_c) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Watchdog: counts WAIT cycles, zero everywhere else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     wdog <= '0;
      else if ((state == S_WAIT) && (state_d == S_WAIT)) wdog <= wdog + WDOG_W'(1);
      else                                            wdog <= '0;
   end

   // Handshake pulses, memory command fields and ownership.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c0_gnt      <= 1'b0;
         c1_gnt      <= 1'b0;
         c0_done     <= 1'b0;
         c1_done     <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         owner       <= C1;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         c0_gnt      <= grant_c && (grant_sel_c == C0);
         c1_gnt      <= grant_c && (grant_sel_c == C1);
         c0_done     <= (finish_c || abort_c) && (owner == C0);
         c1_done     <= (finish_c || abort_c) && (owner == C1);
         timeout_err <= abort_c;
         busy        <= (state_d != S_IDLE);
         if (grant_c) begin
            owner     <= grant_sel_c;
            mem_req   <= 1'b1;
            mem_we    <= (grant_sel_c == C1) ? c1_we    : c0_we;
            mem_addr  <= (grant_sel_c == C1) ? c1_addr  : c0_addr;
            mem_wdata <= (grant_sel_c == C1) ? c1_wdata : c0_wdata;
         end else if (accept_c) begin
            mem_req <= 1'b0;
         end
      end
   end

   // Per-client read data; an aborted transaction returns zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c0_rdata <= '0;
         c1_rdata <= '0;
      end else if (finish_c || abort_c) begin
         if (owner == C0) c0_rdata <= finish_c ? mem_rdata : '0;
         else             c1_rdata <= finish_c ? mem_rdata : '0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table for arbitration plus lock, backpressure, timeout and reset sequences.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        c0_req, c0_we, c0_lock, c1_req, c1_we, c1_lock;
   logic [15:0] c0_addr, c1_addr;
   logic [31:0] c0_wdata, c1_wdata;
   logic        c0_gnt, c0_done, c1_gnt, c1_done;
   logic [31:0] c0_rdata, c1_rdata;
   logic        mem_req, mem_we, mem_ready, mem_done;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        owner, busy, timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .c0_req(c0_req), .c0_we(c0_we), .c0_lock(c0_lock), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
      .c1_req(c1_req), .c1_we(c1_we), .c1_lock(c1_lock), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c0_gnt(c0_gnt), .c0_done(c0_done), .c0_rdata(c0_rdata),
      .c1_gnt(c1_gnt), .c1_done(c1_done), .c1_rdata(c1_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .owner(owner), .busy(busy), .timeout_err(timeout_err)
   );

   // One table row: inputs for a cycle and the outputs expected after its rising edge.
   typedef struct {
      logic        c0_req;
      logic        c1_req;
      logic [15:0] c0_addr;
      logic [15:0] c1_addr;
      logic        rdy;
      logic        dn;
      logic [31:0] rd;
      logic [7:0]  e_ctl;   // {c0_gnt,c1_gnt,c0_done,c1_done,mem_req,owner,busy,timeout_err}
      logic [15:0] e_addr;
      logic [31:0] e_r0;
      logic [31:0] e_r1;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic r0, input logic r1, input logic [15:0] a0,
                               input logic [15:0] a1, input logic rdy, input logic dn,
                               input logic [31:0] rd, input logic [7:0] ctl,
                               input logic [15:0] ea, input logic [31:0] er0, input logic [31:0] er1);
      vec_t v;
      v.c0_req = r0; v.c1_req = r1; v.c0_addr = a0; v.c1_addr = a1;
      v.rdy = rdy; v.dn = dn; v.rd = rd;
      v.e_ctl = ctl; v.e_addr = ea; v.e_r0 = er0; v.e_r1 = er1;
      return v;
   endfunction

   function automatic logic [7:0] ctl_now();
      return {c0_gnt, c1_gnt, c0_done, c1_done, mem_req, owner, busy, timeout_err};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs are driven at the falling edge; outputs are checked at the next falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 1'b0;
      c0_req = 1'b0; c0_we = 1'b0; c0_lock = 1'b0; c0_addr = '0; c0_wdata = 32'h0000_00C0;
      c1_req = 1'b0; c1_we = 1'b0; c1_lock = 1'b0; c1_addr = '0; c1_wdata = 32'h0000_00C1;
      mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("reset_ctl",   32'(ctl_now()), 32'h04);
      chk("reset_addr",  32'(mem_addr), 32'h0);
      chk("reset_rdata", c0_rdata | c1_rdata, 32'h0);

      // Contention from reset (c0 first), single read, contention again (c1 first), ready=0 idle.
      vq.push_back(mk(1'b1,1'b1,16'h0010,16'h0020,1'b1,1'b0,32'h0,        8'h8A,16'h0010,32'h0,        32'h0));
      vq.push_back(mk(1'b0,1'b1,16'h0010,16'h0020,1'b1,1'b0,32'h0,        8'h02,16'h0010,32'h0,        32'h0));
      vq.push_back(mk(1'b0,1'b1,16'h0010,16'h0020,1'b1,1'b1,32'h11111111, 8'h20,16'h0010,32'h11111111, 32'h0));
      vq.push_back(mk(1'b0,1'b1,16'h0010,16'h0020,1'b1,1'b0,32'h0,        8'h4E,16'h0020,32'h11111111, 32'h0));
      vq.push_back(mk(1'b0,1'b0,16'h0010,16'h0020,1'b1,1'b0,32'h0,        8'h06,16'h0020,32'h11111111, 32'h0));
      vq.push_back(mk(1'b0,1'b0,16'h0010,16'h0020,1'b1,1'b1,32'h22222222, 8'h14,16'h0020,32'h11111111, 32'h22222222));
      vq.push_back(mk(1'b1,1'b0,16'h0040,16'h0020,1'b1,1'b0,32'h0,        8'h8A,16'h0040,32'h11111111, 32'h22222222));
      vq.push_back(mk(1'b0,1'b0,16'h0040,16'h0020,1'b1,1'b0,32'h0,        8'h02,16'h0040,32'h11111111, 32'h22222222));
      vq.push_back(mk(1'b0,1'b0,16'h0040,16'h0020,1'b1,1'b0,32'h0,        8'h02,16'h0040,32'h11111111, 32'h22222222));
      vq.push_back(mk(1'b0,1'b0,16'h0040,16'h0020,1'b1,1'b0,32'h0,        8'h02,16'h0040,32'h11111111, 32'h22222222));
      vq.push_back(mk(1'b0,1'b0,16'h0040,16'h0020,1'b1,1'b1,32'hDEADBEEF, 8'h20,16'h0040,32'hDEADBEEF, 32'h22222222));
      vq.push_back(mk(1'b0,1'b0,16'h0040,16'h0020,1'b1,1'b0,32'h0,        8'h00,16'h0040,32'hDEADBEEF, 32'h22222222));
      vq.push_back(mk(1'b1,1'b1,16'h0050,16'h0060,1'b1,1'b0,32'h0,        8'h4E,16'h0060,32'hDEADBEEF, 32'h22222222));
      vq.push_back(mk(1'b1,1'b0,16'h0050,16'h0060,1'b1,1'b0,32'h0,        8'h06,16'h0060,32'hDEADBEEF, 32'h22222222));
      vq.push_back(mk(1'b1,1'b0,16'h0050,16'h0060,1'b1,1'b1,32'h33333333, 8'h14,16'h0060,32'hDEADBEEF, 32'h33333333));
      vq.push_back(mk(1'b1,1'b0,16'h0050,16'h0060,1'b1,1'b0,32'h0,        8'h8A,16'h0050,32'hDEADBEEF, 32'h33333333));
      vq.push_back(mk(1'b0,1'b0,16'h0050,16'h0060,1'b1,1'b0,32'h0,        8'h02,16'h0050,32'hDEADBEEF, 32'h33333333));
      vq.push_back(mk(1'b0,1'b0,16'h0050,16'h0060,1'b1,1'b1,32'h44444444, 8'h20,16'h0050,32'h44444444, 32'h33333333));
      vq.push_back(mk(1'b0,1'b1,16'h0050,16'h0070,1'b0,1'b0,32'h0,        8'h00,16'h0050,32'h44444444, 32'h33333333));
      vq.push_back(mk(1'b0,1'b1,16'h0050,16'h0070,1'b1,1'b0,32'h0,        8'h4E,16'h0070,32'h44444444, 32'h33333333));
      vq.push_back(mk(1'b0,1'b0,16'h0050,16'h0070,1'b1,1'b0,32'h0,        8'h06,16'h0070,32'h44444444, 32'h33333333));
      vq.push_back(mk(1'b0,1'b0,16'h0050,16'h0070,1'b1,1'b1,32'h55555555, 8'h14,16'h0070,32'h44444444, 32'h55555555));

      foreach (vq[i]) begin
         c0_req = vq[i].c0_req; c1_req = vq[i].c1_req;
         c0_addr = vq[i].c0_addr; c1_addr = vq[i].c1_addr;
         mem_ready = vq[i].rdy; mem_done = vq[i].dn; mem_rdata = vq[i].rd;
         step();
         chk($sformatf("vec%0d_ctl", i),    32'(ctl_now()), 32'(vq[i].e_ctl));
         chk($sformatf("vec%0d_addr", i),   32'(mem_addr),  32'(vq[i].e_addr));
         chk($sformatf("vec%0d_rdata0", i), c0_rdata,       vq[i].e_r0);
         chk($sformatf("vec%0d_rdata1", i), c1_rdata,       vq[i].e_r1);
      end
      mem_done = 1'b0;

      // Locked refill of 0x0100..0x0107 by c0 while c1 keeps requesting.
      c1_req = 1'b1; c1_addr = 16'h0200; mem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         c0_req = 1'b1; c0_addr = 16'h0100 + 16'(i); c0_lock = (i < 7);
         step();
         chk($sformatf("lock%0d_gnt0", i), 32'(c0_gnt), 32'h1);
         chk($sformatf("lock%0d_gnt1", i), 32'(c1_gnt), 32'h0);
         chk($sformatf("lock%0d_addr", i), 32'(mem_addr), 32'h0100 + 32'(i));
         c0_req = 1'b0;
         step();
         mem_done = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i);
         step();
         mem_done = 1'b0;
         chk($sformatf("lock%0d_done", i),  32'(c0_done), 32'h1);
         chk($sformatf("lock%0d_rdata", i), c0_rdata, 32'hA000_0000 + 32'(i));
         chk($sformatf("lock%0d_busy", i),  32'(busy), (i < 7) ? 32'h1 : 32'h0);
      end
      c0_lock = 1'b0;
      step();
      chk("lock_release_gnt1", 32'(c1_gnt), 32'h1);
      chk("lock_release_addr", 32'(mem_addr), 32'h0200);
      c1_req = 1'b0;
      step();
      mem_done = 1'b1; mem_rdata = 32'h6666_6666;
      step();
      mem_done = 1'b0;
      chk("lock_c1_done", 32'(c1_done), 32'h1);

      // Backpressure: c0 write stalled five cycles in issue.
      c0_req = 1'b1; c0_we = 1'b1; c0_addr = 16'h0300; c0_wdata = 32'hCAFE_F00D;
      step();
      chk("bp_gnt", 32'(c0_gnt), 32'h1);
      c0_req = 1'b0; c0_we = 1'b0; c0_addr = 16'h0BAD; c0_wdata = 32'h0;
      mem_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         step();
         chk($sformatf("bp%0d_req", n),   32'(mem_req), 32'h1);
         chk($sformatf("bp%0d_we", n),    32'(mem_we), 32'h1);
         chk($sformatf("bp%0d_addr", n),  32'(mem_addr), 32'h0300);
         chk($sformatf("bp%0d_wdata", n), mem_wdata, 32'hCAFE_F00D);
         chk($sformatf("bp%0d_gnt", n),   32'(c0_gnt), 32'h0);
      end
      mem_ready = 1'b1;
      step();
      chk("bp_accept_req",  32'(mem_req), 32'h0);
      chk("bp_accept_busy", 32'(busy), 32'h1);
      mem_done = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      mem_done = 1'b0;
      chk("bp_done", 32'(c0_done), 32'h1);

      // Watchdog abort on a c1 read, then a late completion and a normal retry.
      c1_req = 1'b1; c1_addr = 16'h0400;
      step();
      chk("to_gnt", 32'(c1_gnt), 32'h1);
      c1_req = 1'b0;
      step();
      for (int n = 1; n <= 5; n++) begin
         step();
         chk($sformatf("to_err_at%0d", n),  32'(timeout_err), (n == 5) ? 32'h1 : 32'h0);
         chk($sformatf("to_done_at%0d", n), 32'(c1_done),     (n == 5) ? 32'h1 : 32'h0);
      end
      chk("to_rdata", c1_rdata, 32'h0);
      chk("to_busy",  32'(busy), 32'h0);
      mem_done = 1'b1; mem_rdata = 32'h0000_0BAD;
      step();
      mem_done = 1'b0;
      chk("late_done_ctl",   32'(ctl_now()), 32'h04);
      chk("late_done_rdata", c1_rdata, 32'h0);
      c1_req = 1'b1; c1_addr = 16'h0410;
      step();
      chk("retry_gnt", 32'(c1_gnt), 32'h1);
      c1_req = 1'b0;
      step();
      mem_done = 1'b1; mem_rdata = 32'h7777_7777;
      step();
      mem_done = 1'b0;
      chk("retry_done",  32'(c1_done), 32'h1);
      chk("retry_rdata", c1_rdata, 32'h7777_7777);

      // Reset while c0 waits in WAIT.
      c0_req = 1'b1; c0_addr = 16'h0500;
      step();
      chk("rst_pre_gnt", 32'(c0_gnt), 32'h1);
      c0_req = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rst_ctl",   32'(ctl_now()), 32'h04);
      chk("rst_addr",  32'(mem_addr), 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_we",    32'(mem_we), 32'h0);
      chk("rst_rdata", c0_rdata | c1_rdata, 32'h0);
      mem_done = 1'b1; mem_rdata = 32'h0000_0BAD;
      step();
      mem_done = 1'b0;
      chk("rst_no_done", 32'(ctl_now()), 32'h04);
      c0_req = 1'b1; c1_req = 1'b1; c0_addr = 16'h0600; c1_addr = 16'h0700;
      step();
      chk("rst_tie_ctl",  32'(ctl_now()), 32'h8A);
      chk("rst_tie_addr", 32'(mem_addr), 32'h0600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
